// File: rtl/cpu_bus_resp_pkg.sv
// Shared constants and types for the CPU bus responder.
// Register offsets, CTRL/STATUS bit positions and the CTRL bundle.
package cpu_bus_resp_pkg;

  localparam logic [3:0] OFF_RELOAD_LO = 4'h8;
  localparam logic [3:0] OFF_RELOAD_HI = 4'h9;
  localparam logic [3:0] OFF_CTRL      = 4'hA;
  localparam logic [3:0] OFF_STATUS    = 4'hB;
  localparam logic [3:0] OFF_CNT_LO    = 4'hC;
  localparam logic [3:0] OFF_CNT_HI    = 4'hD;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_AUTO     = 2;
  localparam int STAT_EXPIRED  = 0;
  localparam int STAT_NMI_PEND = 1;

  // Member order puts en at bit 0.
  typedef struct packed {
    logic auto;
    logic irq_en;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/interval_timer16.sv
// 16-bit down counter with one-shot or auto-reload expiry.
// Expiry is flagged combinationally from the registered count.
module interval_timer16 (
  input  logic        clk,
  input  logic        nrst,
  input  logic        load,
  input  logic        en,
  input  logic        auto,
  input  logic [15:0] reload,
  output logic [15:0] count,
  output logic        expire,
  output logic        en_clear
);

  logic [15:0] cnt;

  always_comb begin
    expire   = en && (cnt == 16'h0);
    en_clear = expire && !auto;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt <= 16'h0;
    end else if (load) begin
      cnt <= reload;
    end else if (en) begin
      if (cnt != 16'h0) cnt <= cnt - 16'h1;
      else if (auto)    cnt <= reload;
    end
  end

  assign count = cnt;

endmodule

// File: rtl/cpu_bus_responder.sv
// Bus responder for one 256-byte page: scratch bytes, interval
// timer with IRQ, and a synchronised NMI pushbutton.
module cpu_bus_responder
  import cpu_bus_resp_pkg::*;
#(
  parameter logic [7:0] BASE_PAGE   = 8'hD0,
  parameter int         NUM_SCRATCH = 8
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] addr_hi,
  input  logic [7:0] addr_lo,
  input  logic       cpu_valid,
  input  logic       cpu_rw,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  input  logic       ext_nmi,
  output logic       irq_req,
  output logic       nmi_req
);

  logic        hit;
  logic        wr;
  logic        rd;
  logic [3:0]  off;
  logic        ctrl_wr;
  logic        stat_wr;
  logic        load;
  logic        expire;
  logic        en_clear;
  logic        nmi_rise;
  logic [15:0] count;
  logic [7:0]  rd_mux;
  ctrl_t       ctrl;
  logic [7:0]  reload_lo;
  logic [7:0]  reload_hi;
  logic [7:0]  shadow;
  logic        expired;
  logic        nmi_pend;
  logic [2:0]  nmi_sync;
  logic [7:0]  scratch [8];

  assign hit = cpu_valid && (addr_hi == BASE_PAGE)
            && (addr_lo[7:4] == 4'h0);
  assign off = addr_lo[3:0];
  assign wr  = hit && !cpu_rw;
  assign rd  = hit && cpu_rw;

  assign ctrl_wr  = wr && (off == OFF_CTRL);
  assign stat_wr  = wr && (off == OFF_STATUS);
  assign load     = ctrl_wr && cpu_wdata[CTRL_EN] && !ctrl.en;
  // [2] is the previous synchronised level for edge detection
  assign nmi_rise = nmi_sync[1] && !nmi_sync[2];

  interval_timer16 u_timer (
    .clk      (clk),
    .nrst     (nrst),
    .load     (load),
    .en       (ctrl.en),
    .auto     (ctrl.auto),
    .reload   ({reload_hi, reload_lo}),
    .count    (count),
    .expire   (expire),
    .en_clear (en_clear)
  );

  always_comb begin
    rd_mux = 8'h00;
    if (!off[3]) begin
      if (int'(off[2:0]) < NUM_SCRATCH) rd_mux = scratch[off[2:0]];
    end else begin
      case (off)
        OFF_RELOAD_LO: rd_mux = reload_lo;
        OFF_RELOAD_HI: rd_mux = reload_hi;
        OFF_CTRL:      rd_mux = {5'b0, ctrl};
        OFF_STATUS:    rd_mux = {6'b0, nmi_pend, expired};
        OFF_CNT_LO:    rd_mux = count[7:0];
        OFF_CNT_HI:    rd_mux = shadow;
        default:       rd_mux = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < 8; i++) scratch[i] <= 8'h00;
      reload_lo   <= 8'h00;
      reload_hi   <= 8'h00;
      ctrl        <= '0;
      expired     <= 1'b0;
      nmi_pend    <= 1'b0;
      nmi_sync    <= 3'b000;
      shadow      <= 8'h00;
      rdata       <= 8'h00;
      rdata_valid <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (wr && off == 4'(i) && i < NUM_SCRATCH)
          scratch[i] <= cpu_wdata;
      end
      if (wr && off == OFF_RELOAD_LO) reload_lo <= cpu_wdata;
      if (wr && off == OFF_RELOAD_HI) reload_hi <= cpu_wdata;
      // A bus write to CTRL overrides the one-shot auto-disable
      if (ctrl_wr)       ctrl    <= ctrl_t'(cpu_wdata[2:0]);
      else if (en_clear) ctrl.en <= 1'b0;
      expired  <= (expired && !(stat_wr && cpu_wdata[STAT_EXPIRED]))
               || expire;
      nmi_pend <= (nmi_pend && !(stat_wr && cpu_wdata[STAT_NMI_PEND]))
               || nmi_rise;
      nmi_sync <= {nmi_sync[1:0], ext_nmi};
      rdata_valid <= rd;
      if (rd) rdata <= rd_mux;
      if (rd && off == OFF_CNT_LO) shadow <= count[15:8];
    end
  end

  assign irq_req = expired && ctrl.irq_en;
  assign nmi_req = nmi_pend;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Self-checking bench: vector table, timer/NMI/reset sequences
// and randomized accesses against a register-map model.
module tb_cpu_bus_responder;

  logic       clk = 1'b0;
  logic       nrst;
  logic [7:0] addr_hi;
  logic [7:0] addr_lo;
  logic       cpu_valid;
  logic       cpu_rw;
  logic [7:0] cpu_wdata;
  logic [7:0] rdata;
  logic       rdata_valid;
  logic       ext_nmi;
  logic       irq_req;
  logic       nmi_req;

  int checks = 0;
  int errors = 0;

  cpu_bus_responder #(.BASE_PAGE(8'hD0), .NUM_SCRATCH(8)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .addr_hi     (addr_hi),
    .addr_lo     (addr_lo),
    .cpu_valid   (cpu_valid),
    .cpu_rw      (cpu_rw),
    .cpu_wdata   (cpu_wdata),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .ext_nmi     (ext_nmi),
    .irq_req     (irq_req),
    .nmi_req     (nmi_req)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    logic       rw;
    logic [7:0] hi;
    logic [7:0] lo;
    logic [7:0] wd;
    logic       exp_valid;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic rw, input logic [7:0] hi,
                     input logic [7:0] lo, input logic [7:0] wd);
    cpu_rw    = rw;
    addr_hi   = hi;
    addr_lo   = lo;
    cpu_wdata = wd;
    cpu_valid = 1'b1;
    tick();
    cpu_valid = 1'b0;
  endtask

  task automatic wr(input logic [7:0] lo, input logic [7:0] wd);
    bus(1'b0, 8'hD0, lo, wd);
  endtask

  task automatic rd(input logic [7:0] lo, input logic [7:0] exp,
                    input string name);
    bus(1'b1, 8'hD0, lo, 8'h00);
    check({name, "_valid"}, rdata_valid, 1);
    check(name, rdata, exp);
  endtask

  logic [7:0] mem [16];
  logic [7:0] last;

  initial begin
    nrst = 1'b0; addr_hi = 0; addr_lo = 0; cpu_valid = 0;
    cpu_rw = 0; cpu_wdata = 0; ext_nmi = 0;
    #3;
    check("reset_rdata", rdata, 0);
    check("reset_valid", rdata_valid, 0);
    check("reset_irq", irq_req, 0);
    check("reset_nmi", nmi_req, 0);
    tick(); tick();
    nrst = 1'b1;
    tick();

    vecs[0]  = '{0, 8'hD0, 8'h03, 8'h5A, 0, 8'h00};
    vecs[1]  = '{1, 8'hD0, 8'h03, 8'h00, 1, 8'h5A};
    vecs[2]  = '{1, 8'hC0, 8'h03, 8'h00, 0, 8'h5A};
    vecs[3]  = '{0, 8'hD0, 8'h07, 8'hC3, 0, 8'h5A};
    vecs[4]  = '{1, 8'hD0, 8'h07, 8'h00, 1, 8'hC3};
    vecs[5]  = '{1, 8'hD0, 8'h13, 8'h00, 0, 8'hC3};
    vecs[6]  = '{0, 8'hD0, 8'h08, 8'h34, 0, 8'hC3};
    vecs[7]  = '{0, 8'hD0, 8'h09, 8'h12, 0, 8'hC3};
    vecs[8]  = '{1, 8'hD0, 8'h08, 8'h00, 1, 8'h34};
    vecs[9]  = '{1, 8'hD0, 8'h09, 8'h00, 1, 8'h12};
    vecs[10] = '{1, 8'hD0, 8'h0A, 8'h00, 1, 8'h00};
    vecs[11] = '{0, 8'hD0, 8'h0E, 8'hFF, 0, 8'h00};
    vecs[12] = '{1, 8'hD0, 8'h0E, 8'h00, 1, 8'h00};
    vecs[13] = '{1, 8'hD0, 8'h0B, 8'h00, 1, 8'h00};
    vecs[14] = '{0, 8'hD0, 8'hF3, 8'h11, 0, 8'h00};
    vecs[15] = '{1, 8'hD0, 8'h03, 8'h00, 1, 8'h5A};
    for (int i = 0; i < 16; i++) begin
      bus(vecs[i].rw, vecs[i].hi, vecs[i].lo, vecs[i].wd);
      check($sformatf("vec%0d_valid", i), rdata_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
    end
    tick();
    check("valid_one_cycle", rdata_valid, 0);

    // periodic auto-reload timer with IRQ
    wr(8'h08, 8'h03);
    wr(8'h09, 8'h00);
    wr(8'h0A, 8'h07);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("auto_irq_c%0d", k), irq_req, k == 4);
    end
    wr(8'h0B, 8'h01);
    check("w1c_irq_drop", irq_req, 0);
    tick(); check("w1c_irq_low1", irq_req, 0);
    tick(); check("w1c_irq_low2", irq_req, 0);
    tick(); check("auto_irq_again", irq_req, 1);
    tick(); tick(); tick();
    wr(8'h0B, 8'h01);
    check("w1c_vs_expire", irq_req, 1);
    wr(8'h0B, 8'h01);
    check("w1c_clears", irq_req, 0);
    rd(8'h0B, 8'h00, "status_clear");
    wr(8'h0A, 8'h00);

    // one-shot
    wr(8'h08, 8'h02);
    wr(8'h0A, 8'h01);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("oneshot_irq_c%0d", k), irq_req, 0);
    end
    rd(8'h0A, 8'h00, "oneshot_ctrl");
    rd(8'h0B, 8'h01, "oneshot_status");
    rd(8'h0C, 8'h00, "oneshot_cnt");
    check("oneshot_irq", irq_req, 0);
    wr(8'h0B, 8'h01);

    // shadowed high byte
    wr(8'h08, 8'h01);
    wr(8'h09, 8'h01);
    wr(8'h0A, 8'h01);
    tick();
    rd(8'h0C, 8'h00, "cnt_lo");
    rd(8'h0D, 8'h01, "cnt_hi_shadow");
    wr(8'h0A, 8'h00);

    // NMI pushbutton held
    ext_nmi = 1'b1;
    tick(); check("nmi_c1", nmi_req, 0);
    tick(); check("nmi_c2", nmi_req, 0);
    tick(); check("nmi_c3", nmi_req, 1);
    rd(8'h0B, 8'h02, "nmi_status");
    repeat (14) tick();
    check("nmi_held", nmi_req, 1);
    wr(8'h0B, 8'h02);
    check("nmi_w1c", nmi_req, 0);
    repeat (4) tick();
    check("nmi_no_reset", nmi_req, 0);
    ext_nmi = 1'b0;
    repeat (3) tick();
    check("nmi_release", nmi_req, 0);

    // reload 0 with auto expires every cycle, then reset mid-access
    wr(8'h08, 8'h00);
    wr(8'h09, 8'h00);
    wr(8'h0A, 8'h07);
    tick();
    check("zero_reload_irq", irq_req, 1);
    wr(8'h0B, 8'h01);
    check("zero_reload_w1c", irq_req, 1);
    rd(8'h03, 8'h5A, "pre_reset_rd");
    cpu_rw = 1'b1; addr_hi = 8'hD0; addr_lo = 8'h03; cpu_valid = 1'b1;
    #2 nrst = 1'b0;
    #1;
    check("mid_rst_rdata", rdata, 0);
    check("mid_rst_valid", rdata_valid, 0);
    check("mid_rst_irq", irq_req, 0);
    check("mid_rst_nmi", nmi_req, 0);
    cpu_valid = 1'b0;
    tick(); tick();
    nrst = 1'b1;
    tick();
    check("post_rst_valid", rdata_valid, 0);
    repeat (10) tick();
    check("post_rst_irq", irq_req, 0);
    rd(8'h0A, 8'h00, "post_rst_ctrl");
    rd(8'h0C, 8'h00, "post_rst_cnt");
    rd(8'h0B, 8'h00, "post_rst_status");
    rd(8'h03, 8'h00, "post_rst_scratch");

    // random accesses against a register-map model
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    last = rdata;
    for (int n = 0; n < 300; n++) begin
      logic       r;
      logic [7:0] h;
      logic [7:0] l;
      logic [7:0] d;
      logic       hit;
      logic [3:0] o;
      r = 1'($urandom_range(0, 1));
      h = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hD0;
      l = ($urandom_range(0, 4) == 0) ? 8'($urandom)
                                      : {4'h0, 4'($urandom)};
      d = 8'($urandom);
      o = l[3:0];
      if (!r && o == 4'hA) r = 1'b1;
      hit = (h == 8'hD0) && (l[7:4] == 4'h0);
      bus(r, h, l, d);
      if (hit && !r && (o < 4'd10)) mem[o] = d;
      if (hit && r) last = mem[o];
      check($sformatf("rnd%0d_valid", n), rdata_valid, hit && r);
      check($sformatf("rnd%0d_rdata", n), rdata, last);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_bus_responder.md
Name: cpu_bus_responder

Overview:
- Memory-side responder for the 8227 CPU bus. It answers the CPU's address/data requests in one 256-byte page.
- The page holds 8 scratch bytes and a 16-bit interval timer.
- It drives the CPU's interruptRequest and nonMaskableInterrupt inputs.
- Sits beside top8227 in the chip top: CPU is initiator, this block is responder.

Parameters:
- BASE_PAGE, 8'hD0, value of the address high byte that selects this block.
- NUM_SCRATCH, 8, number of scratch bytes at offsets 0..NUM_SCRATCH-1. Must be 8 or fewer.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- addr_hi  in  8  CPU address bus high byte
- addr_lo  in  8  CPU address bus low byte
- cpu_valid  in  1  one-cycle access strobe; address, cpu_rw and cpu_wdata are valid while it is high
- cpu_rw  in  1  1 = read, 0 = write
- cpu_wdata  in  8  CPU data bus output (write data)
- rdata  out  8  read data to CPU data bus input
- rdata_valid  out  1  high for one cycle when rdata holds a response
- ext_nmi  in  1  asynchronous NMI pushbutton, active high
- irq_req  out  1  level interrupt request to the CPU
- nmi_req  out  1  NMI request level to the CPU; the CPU detects its rising edge

Behaviour:
- Reset (nrst low, asynchronous) clears every register and output:
  - rdata=0, rdata_valid=0, irq_req=0, nmi_req=0
  - scratch, reload, count, CTRL and STATUS all 0
  - NMI synchroniser flops 0
- Select: hit = cpu_valid & (addr_hi==BASE_PAGE) & (addr_lo[7:4]==0). Offset = addr_lo[3:0].
  - A cpu_valid without hit: no state change, rdata_valid stays 0, rdata holds its previous value.
- Reads: registered, 1-cycle latency. rdata and rdata_valid update on the edge after the hit cycle.
- Writes: take effect on the edge that samples the hit. rdata_valid stays 0.
- Register map (offset):
  - 0x0-0x7: scratch, read/write. Offsets at or above NUM_SCRATCH read 0; writes to them are ignored.
  - 0x8: RELOAD_LO, read/write.
  - 0x9: RELOAD_HI, read/write.
  - 0xA: CTRL. bit0 EN, bit1 IRQ_EN, bit2 AUTO. Bits 7:3 read 0.
  - 0xB: STATUS. bit0 EXPIRED, bit1 NMI_PEND. Write-1-to-clear.
  - 0xC: CNT_LO. Read returns count[7:0] and copies count[15:8] into the shadow register.
  - 0xD: CNT_HI. Read returns the shadow register; writes ignored.
  - 0xE-0xF: read 0x00, writes ignored.
- Timer:
  - A write to CTRL that takes EN from 0 to 1 loads count from {RELOAD_HI, RELOAD_LO}.
  - While EN=1 and count!=0: count decrements by 1 each clk.
  - While EN=1 and count==0: set EXPIRED. Then, if AUTO=1, reload count. If AUTO=0, clear EN; count stays 0.
  - Reload value 0 with AUTO=1 sets EXPIRED every cycle.
  - Writing RELOAD while running does not change count; the new value applies at the next reload.
  - While EN=0, count holds its value.
- irq_req = EXPIRED & IRQ_EN, from registered bits, so it is glitch-free.
- NMI:
  - ext_nmi passes through a 2-flop synchroniser.
  - A rising edge of the synchronised signal sets NMI_PEND. nmi_req = NMI_PEND.
  - A held button produces only one set.
- Simultaneous events:
  - A hardware set beats a W1C write in the same cycle; the bit stays 1.
  - A CTRL write that clears EN in the expiry cycle: the write wins; EXPIRED is still set that cycle.
  - A CTRL write that sets EN while EN is already 1 does not reload.
  - A CNT_LO read during decrement returns the pre-edge count; the shadow copy is from the same pre-edge value.
- Reset asserted mid-access aborts the access. No pending response survives reset.

Decomposition:
- Package cpu_bus_resp_pkg:
  - offset constants (OFF_RELOAD_LO .. OFF_CNT_HI)
  - CTRL/STATUS bit indices
  - typedef ctrl_t (packed struct: en, irq_en, auto)
- One sub-module, interval_timer16:
  - inputs: load, en, auto, reload[15:0]
  - outputs: count[15:0], expire pulse, en_clear
- Bus decode, register file, status and NMI logic stay in cpu_bus_responder.

Test Plan:
- Write 0x5A to 0xD003, then read 0xD003 -> rdata=0x5A with rdata_valid high exactly 1 cycle after the read strobe. A read of 0xC003 -> no rdata_valid.
- RELOAD=0x0003, CTRL=0x07 -> EXPIRED and irq_req rise 4 cycles after the EN edge and repeat every 4 cycles. Writing STATUS=0x01 drops irq_req for 3 cycles.
- RELOAD=0x0002, CTRL=0x01 (one-shot) -> EXPIRED set once. Then CTRL reads 0x00, count=0, irq_req stays 0 (IRQ_EN=0).
- Counter at 0x0100 decrementing: read 0xD00C then 0xD00D -> 0x00 then 0x01 (shadow), not 0x00.
- Hold ext_nmi high for 20 cycles -> nmi_req rises 3 cycles later and stays high. NMI_PEND is set once. Writing STATUS=0x02 while the button is still held clears nmi_req with no re-set.
- W1C of EXPIRED in the same cycle as an expiry -> EXPIRED remains 1. Assert nrst mid-count -> all outputs 0 immediately, and the timer stays stopped after release.
